// File: rtl/rf_frame_receiver.sv
// rf_frame_receiver: hunts for a sync word in the decoded bit stream, then deframes length, payload and CRC-8.
// Defining RX_CRC8_EN enables the trailing CRC-8 byte check; without it crc_ok is 1 with every frame_done.
module rf_frame_receiver #(
    parameter logic [15:0] SYNC_WORD = 16'h2DD4,
    parameter int unsigned MAX_LEN   = 32
) (
    input  logic       clk2x,
    input  logic       rst_n,
    input  logic       bit_in,
    input  logic       bit_stb,
    input  logic       bit_err,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic [7:0] frame_len,
    output logic       in_frame,
    output logic       frame_done,
    output logic       crc_ok,
    output logic       frame_err
);
    localparam logic [7:0] MAX_LEN_B = MAX_LEN[7:0];

    typedef enum logic [2:0] {S_HUNT, S_LEN, S_DATA, S_CRC, S_DONE} state_e;

    state_e      state_q, state_d;
    logic [15:0] shift_q, shift_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  byte_data_q, byte_data_d;
    logic        byte_valid_q, byte_valid_d;
    logic [7:0]  frame_len_q, frame_len_d;
    logic        in_frame_q, in_frame_d;
    logic        frame_done_q, frame_done_d;
    logic        crc_ok_q, crc_ok_d;
    logic        frame_err_q, frame_err_d;

    logic [15:0] shift_in;
    logic [7:0]  rx_byte;
    assign shift_in = {shift_q[14:0], bit_in};
    assign rx_byte  = shift_in[7:0];

`ifdef RX_CRC8_EN
    logic [7:0] crc_q, crc_d, crc_next;
    // Serial CRC-8, poly 0x07, MSB-first.
    assign crc_next = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ bit_in) ? 8'h07 : 8'h00);
`endif

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        byte_data_d  = byte_data_q;
        byte_valid_d = 1'b0;
        frame_len_d  = frame_len_q;
        in_frame_d   = in_frame_q;
        frame_done_d = 1'b0;
        crc_ok_d     = crc_ok_q;
        frame_err_d  = 1'b0;
`ifdef RX_CRC8_EN
        crc_d        = crc_q;
`endif
        case (state_q)
            S_HUNT: begin
                if (bit_err) begin
                    shift_d = '0;
                end else if (bit_stb) begin
                    shift_d = shift_in;
                    if (shift_in == SYNC_WORD) begin
                        state_d    = S_LEN;
                        in_frame_d = 1'b1;
                        bit_cnt_d  = 3'd0;
                        byte_cnt_d = 8'd0;
`ifdef RX_CRC8_EN
                        crc_d      = 8'h00;
`endif
                    end
                end
            end
            S_LEN, S_DATA, S_CRC: begin
                if (bit_err) begin
                    // Abort wins over a coincident strobe; the window is cleared so no stale bits re-match.
                    frame_err_d = 1'b1;
                    in_frame_d  = 1'b0;
                    shift_d     = '0;
                    state_d     = S_HUNT;
                end else if (bit_stb) begin
                    shift_d   = shift_in;
                    bit_cnt_d = bit_cnt_q + 3'd1;
`ifdef RX_CRC8_EN
                    if (state_q != S_CRC) crc_d = crc_next;
`endif
                    if (bit_cnt_q == 3'd7) begin
                        if (state_q == S_LEN) begin
                            frame_len_d = rx_byte;
                            byte_cnt_d  = 8'd0;
                            if (rx_byte == 8'd0 || rx_byte > MAX_LEN_B) begin
                                frame_err_d = 1'b1;
                                in_frame_d  = 1'b0;
                                shift_d     = '0;
                                state_d     = S_HUNT;
                            end else begin
                                state_d = S_DATA;
                            end
                        end else if (state_q == S_DATA) begin
                            byte_data_d  = rx_byte;
                            byte_valid_d = 1'b1;
                            byte_cnt_d   = byte_cnt_q + 8'd1;
                            if (byte_cnt_q == frame_len_q - 8'd1) begin
`ifdef RX_CRC8_EN
                                state_d = S_CRC;
`else
                                state_d      = S_DONE;
                                frame_done_d = 1'b1;
                                crc_ok_d     = 1'b1;
                                in_frame_d   = 1'b0;
                                shift_d      = '0;
`endif
                            end
                        end else begin
                            state_d      = S_DONE;
                            frame_done_d = 1'b1;
`ifdef RX_CRC8_EN
                            crc_ok_d     = (rx_byte == crc_q);
`else
                            crc_ok_d     = 1'b1;
`endif
                            in_frame_d   = 1'b0;
                            shift_d      = '0;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_HUNT;
                shift_d = '0;
            end
            default: state_d = S_HUNT;
        endcase
    end

    always_ff @(posedge clk2x or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_HUNT;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            byte_data_q  <= '0;
            byte_valid_q <= 1'b0;
            frame_len_q  <= '0;
            in_frame_q   <= 1'b0;
            frame_done_q <= 1'b0;
            crc_ok_q     <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef RX_CRC8_EN
            crc_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            byte_data_q  <= byte_data_d;
            byte_valid_q <= byte_valid_d;
            frame_len_q  <= frame_len_d;
            in_frame_q   <= in_frame_d;
            frame_done_q <= frame_done_d;
            crc_ok_q     <= crc_ok_d;
            frame_err_q  <= frame_err_d;
`ifdef RX_CRC8_EN
            crc_q        <= crc_d;
`endif
        end
    end

    assign byte_data  = byte_data_q;
    assign byte_valid = byte_valid_q;
    assign frame_len  = frame_len_q;
    assign in_frame   = in_frame_q;
    assign frame_done = frame_done_q;
    assign crc_ok     = crc_ok_q;
    assign frame_err  = frame_err_q;
endmodule
